// File: rtl/snina_pkg.sv
// Shared definitions for the SNINA masked/duplicated datapath decoders:
// default orders, share/copy indexing and the decoder FSM encoding.
package snina_pkg;

    localparam int D_DEFAULT = 2;
    localparam int K_DEFAULT = 1;
    localparam int NSH       = D_DEFAULT + 1;
    localparam int NCP       = K_DEFAULT + 1;

    // Flat bit position of share i, copy k inside a bit-slice.
    function automatic int share_copy_idx(input int i, input int k, input int ncp = NCP);
        return i * ncp + k;
    endfunction

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PRESENT = 2'd1,
        ALARM   = 2'd2
    } state_e;

endpackage

// File: rtl/snina_beat_check.sv
// Combinational check of one bit-slice: copy consistency, upstream flags,
// and recombination of the Boolean shares into the plain bit.
module snina_beat_check
    import snina_pkg::*;
#(
    parameter int D = D_DEFAULT,
    parameter int K = K_DEFAULT
) (
    input  logic [(D+1)*(K+1)-1:0] port_s,
    input  logic [D:0]             port_errorFlag,
    output logic                   plain_bit,
    output logic                   beat_ok
);

    logic copy_ok;

    // NOTE: every variable written here gets a default first, so no path
    // through the loops can leave one unassigned and infer a latch.
    always_comb begin
        copy_ok   = 1'b1;
        plain_bit = 1'b0;
        for (int i = 0; i <= D; i++) begin
            for (int k = 1; k <= K; k++) begin
                if (port_s[share_copy_idx(i, k, K + 1)] != port_s[share_copy_idx(i, 0, K + 1)]) begin
                    copy_ok = 1'b0;
                end
            end
            plain_bit = plain_bit ^ port_s[share_copy_idx(i, 0, K + 1)];
        end
    end

    assign beat_ok = copy_ok & (&port_errorFlag);

endmodule

// File: rtl/snina_unmask_decoder.sv
// Output end of the SNINA datapath: checks each beat, assembles W plain bits
// into a word, presents it over valid/ready, and locks up on any fault.
module snina_unmask_decoder
    import snina_pkg::*;
#(
    parameter int D = D_DEFAULT,
    parameter int K = K_DEFAULT,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [(D+1)*(K+1)-1:0] port_s,
    input  logic [D:0]             port_errorFlag,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [W-1:0]           port_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   port_alarm
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    shift_q, shift_d;
    logic            plain_bit;
    logic            beat_ok;

    snina_beat_check #(
        .D(D),
        .K(K)
    ) u_beat_check (
        .port_s         (port_s),
        .port_errorFlag (port_errorFlag),
        .plain_bit      (plain_bit),
        .beat_ok        (beat_ok)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        port_y     = '0;
        port_alarm = 1'b0;

        case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                // Beat inputs are only looked at when in_valid is high, so
                // undriven data between beats cannot disturb state.
                if (in_valid) begin
                    if (!beat_ok) begin
                        state_d = ALARM;
                    end else begin
                        shift_d[cnt_q] = plain_bit;
                        if (cnt_q == CW'(W - 1)) begin
                            cnt_d   = '0;
                            state_d = PRESENT;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            PRESENT: begin
                out_valid = 1'b1;
                port_y    = shift_q;
                if (out_ready) begin
                    shift_d = '0;
                    state_d = COLLECT;
                end
            end
            ALARM: begin
                port_alarm = 1'b1;
            end
            default: begin
                state_d = ALARM;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: tb/tb_snina_unmask_decoder.sv
// Directed self-checking bench for snina_unmask_decoder with D=2, K=1, W=8.
module tb_snina_unmask_decoder;

    localparam logic [5:0] S_ONE  = 6'b111111;
    localparam logic [5:0] S_ZERO = 6'b110011;

    logic       clk;
    logic       reset;
    logic [5:0] port_s;
    logic [2:0] port_errorFlag;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] port_y;
    logic       out_valid;
    logic       out_ready;
    logic       port_alarm;

    int checks   = 0;
    int failures = 0;

    snina_unmask_decoder #(
        .D(2),
        .K(1),
        .W(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .port_s         (port_s),
        .port_errorFlag (port_errorFlag),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .port_y         (port_y),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .port_alarm     (port_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_raw(input logic [5:0] s, input logic [2:0] flags);
        in_valid       = 1'b1;
        port_s         = s;
        port_errorFlag = flags;
        tick();
    endtask

    task automatic beat(input logic b);
        drive_raw(b ? S_ONE : S_ZERO, 3'b111);
    endtask

    task automatic idle();
        in_valid       = 1'b0;
        port_s         = 'x;
        port_errorFlag = 'x;
        tick();
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (port_y !== 8'h00) begin
            failures++;
            $display("FAIL reset_port_y got=%h exp=00", port_y);
        end
        checks++;
        if (port_alarm !== 1'b0) begin
            failures++;
            $display("FAIL reset_alarm got=%b exp=0", port_alarm);
        end
    endtask

    task automatic test_basic_word();
        logic [7:0] w;
        w = 8'hA5;
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            beat(w[j]);
            if (j < 7) begin
                checks++;
                if (out_valid !== 1'b0 || port_y !== 8'h00 || port_alarm !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_partial beat=%0d got valid=%b y=%h alarm=%b exp valid=0 y=00 alarm=0",
                             j, out_valid, port_y, port_alarm);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || port_y !== 8'hA5 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_present got valid=%b y=%h ready=%b exp valid=1 y=a5 ready=0",
                     out_valid, port_y, in_ready);
        end
        idle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || port_y !== 8'h00 || port_alarm !== 1'b0) begin
            failures++;
            $display("FAIL basic_release got valid=%b ready=%b y=%h alarm=%b exp valid=0 ready=1 y=00 alarm=0",
                     out_valid, in_ready, port_y, port_alarm);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w;
        w = 8'h3C;
        out_ready = 1'b0;
        for (int j = 0; j < 8; j++) beat(w[j]);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || port_y !== 8'h3C || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall cycle=%0d got valid=%b y=%h ready=%b exp valid=1 y=3c ready=0",
                         c, out_valid, port_y, in_ready);
            end
            beat(1'b1);
        end
        out_ready = 1'b1;
        beat(1'b1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
        end
        w = 8'h01;
        for (int j = 0; j < 8; j++) beat(w[j]);
        checks++;
        if (out_valid !== 1'b1 || port_y !== 8'h01) begin
            failures++;
            $display("FAIL after_stall_word got valid=%b y=%h exp valid=1 y=01", out_valid, port_y);
        end
        idle();
    endtask

    task automatic test_copy_fault();
        do_reset();
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) beat(1'b1);
        drive_raw(6'b111101, 3'b111);
        checks++;
        if (port_alarm !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || port_y !== 8'h00) begin
            failures++;
            $display("FAIL copy_fault got alarm=%b ready=%b valid=%b y=%h exp alarm=1 ready=0 valid=0 y=00",
                     port_alarm, in_ready, out_valid, port_y);
        end
        for (int c = 0; c < 20; c++) begin
            beat(1'b1);
            checks++;
            if (port_alarm !== 1'b1 || out_valid !== 1'b0 || port_y !== 8'h00 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL alarm_hold cycle=%0d got alarm=%b valid=%b y=%h ready=%b exp alarm=1 valid=0 y=00 ready=0",
                         c, port_alarm, out_valid, port_y, in_ready);
            end
        end
    endtask

    task automatic test_flag_fault();
        do_reset();
        in_valid       = 1'b0;
        port_s         = S_ONE;
        port_errorFlag = 3'b101;
        tick();
        checks++;
        if (port_alarm !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flag_idle got alarm=%b ready=%b exp alarm=0 ready=1", port_alarm, in_ready);
        end
        drive_raw(S_ONE, 3'b101);
        checks++;
        if (port_alarm !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flag_fault got alarm=%b ready=%b exp alarm=1 ready=0", port_alarm, in_ready);
        end
    endtask

    task automatic test_reset_recovery();
        do_reset();
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) beat(1'b0);
        do_reset();
        checks++;
        if (port_alarm !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midword_reset got alarm=%b ready=%b valid=%b exp alarm=0 ready=1 valid=0",
                     port_alarm, in_ready, out_valid);
        end
        drive_raw(S_ONE, 3'b011);
        do_reset();
        checks++;
        if (port_alarm !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL alarm_reset got alarm=%b ready=%b exp alarm=0 ready=1", port_alarm, in_ready);
        end
        for (int j = 0; j < 7; j++) beat(1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL recovery_count got valid=%b exp=0 after 7 beats", out_valid);
        end
        beat(1'b1);
        checks++;
        if (out_valid !== 1'b1 || port_y !== 8'hFF) begin
            failures++;
            $display("FAIL recovery_word got valid=%b y=%h exp valid=1 y=ff", out_valid, port_y);
        end
        idle();
    endtask

    task automatic test_gaps();
        logic [7:0] w;
        w = 8'h96;
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            beat(w[j]);
            if (j == 7) begin
                checks++;
                if (out_valid !== 1'b1 || port_y !== 8'h96) begin
                    failures++;
                    $display("FAIL gaps_word got valid=%b y=%h exp valid=1 y=96", out_valid, port_y);
                end
            end else begin
                idle();
                checks++;
                if (out_valid !== 1'b0 || port_y !== 8'h00) begin
                    failures++;
                    $display("FAIL gaps_partial beat=%0d got valid=%b y=%h exp valid=0 y=00",
                             j, out_valid, port_y);
                end
            end
        end
        idle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || port_alarm !== 1'b0) begin
            failures++;
            $display("FAIL gaps_release got valid=%b ready=%b alarm=%b exp valid=0 ready=1 alarm=0",
                     out_valid, in_ready, port_alarm);
        end
    endtask

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        port_s         = '0;
        port_errorFlag = 3'b111;
        test_reset();
        test_basic_word();
        test_backpressure();
        test_copy_fault();
        test_flag_fault();
        test_reset_recovery();
        test_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snina_unmask_decoder.md
Name: snina_unmask_decoder

Overview:
Output end of the SNINA masked/duplicated datapath. Accepts one bit-slice per handshake: D+1 Boolean shares, each carried as K+1 duplicate copies, plus the upstream per-share consistency flags.
- Checks copy consistency.
- Recombines the shares into the plain bit.
- Assembles W bits into a word and hands it downstream over valid/ready.
- Any fault latches a sticky alarm and suppresses all further output.

Parameters:
D, 2, masking order; number of shares = D+1
K, 1, duplication order; copies per share = K+1
W, 8, plain bits per output word (W >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; state cleared on a clk edge where reset==0
port_s  input  (D+1)*(K+1)  one bit-slice; bit [i*(K+1)+k] = share i, copy k
port_errorFlag  input  D+1  upstream flags; 1 = share consistent, 0 = fault detected
in_valid  input  1  port_s/port_errorFlag valid
in_ready  output  1  decoder can accept a beat
port_y  output  W  unmasked word; bit j = j-th accepted beat (LSB first)
out_valid  output  1  port_y valid
out_ready  input  1  downstream accepts port_y
port_alarm  output  1  sticky fault indicator

Behaviour:
Reset (reset==0 at an edge):
- State goes to COLLECT; beat counter = 0; shift register = 0; alarm = 0.
- Output reset values: in_ready=1, out_valid=0, port_y=0, port_alarm=0.
- Reset applies mid-word and in ALARM; the partial word is discarded.

Beat check (combinational, only meaningful on accept = in_valid & in_ready):
- copy_ok = for every share i, all K+1 copies equal.
- flag_ok = all bits of port_errorFlag == 1.
- bit = XOR over i of share i copy 0.
- fault = accept & !(copy_ok & flag_ok).

FSM: states COLLECT, PRESENT, ALARM.
- COLLECT: in_ready=1, out_valid=0.
  - On accept without fault: shift bit into position cnt; cnt += 1.
  - On the W-th accept (cnt==W-1): cnt wraps to 0, next state PRESENT.
- PRESENT: in_ready=0, out_valid=1, port_y holds the assembled word stable.
  - On out_ready: next state COLLECT, shift register cleared.
  - port_y must not change while out_valid=1 and out_ready=0.
- ALARM: in_ready=0, out_valid=0, port_alarm=1, port_y forced to 0. Terminal; only reset exits.
- Any fault in COLLECT goes to ALARM at the next edge. The offending bit is not stored.

Timing and output rules:
- Latency: out_valid rises the cycle after the W-th accepted beat.
- Throughput: W+1 cycles per word when out_ready is held at 1; no same-cycle bypass.
- port_y = 0 whenever out_valid=0 (no leakage of partial words).
- port_alarm is registered, asserted the cycle after the faulty accept, and stays high until reset.
- in_valid while in_ready=0 is ignored (beat not consumed, no fault evaluation).
- Inputs marked X while in_valid=0 must not affect state.

Decomposition:
Shared package snina_pkg holds:
- D, K defaults and the localparams NSH=D+1, NCP=K+1.
- Index helper function share_copy_idx(i,k).
- FSM enum {COLLECT, PRESENT, ALARM}.

One sub-module, snina_beat_check: purely combinational; port_s and port_errorFlag in, bit and ok out. It is reused by later decoders. The top level holds the FSM, counter and shift register.

Test Plan (D=2, K=1, W=8; plain bit 1 sent as port_s=6'b111111, 0 as 6'b110011; flags=3'b111):
- Basic word: after reset, send 0xA5 LSB first with in_valid held high and out_ready=1 -> one cycle after beat 8: out_valid=1, port_y=8'hA5, in_ready=0. Next cycle: in_ready=1, out_valid=0, port_alarm=0 throughout.
- Backpressure: send 0x3C with out_ready=0 for 5 cycles -> port_y=8'h3C held stable, in_ready=0. Beats offered meanwhile (in_valid=1) are not consumed. After out_ready=1, the next word 0x01 decodes correctly.
- Copy fault: beat 3 has port_s=6'b111101 (share 0 copies differ) -> next cycle port_alarm=1, in_ready=0, out_valid never asserts, port_y=0 for 20 further cycles.
- Upstream flag fault: a clean port_s but port_errorFlag=3'b101 on beat 0 -> ALARM next cycle. The same flag value presented with in_valid=0 -> no alarm.
- Reset recovery: reset=0 for one cycle mid-word (after 4 beats) and while in ALARM -> port_alarm=0, in_ready=1, cnt=0. A fresh 0xFF then decodes as 8'hFF, with no bits from the prior partial word.
- Gaps: 0x96 sent with in_valid deasserted every other cycle -> port_y=8'h96 presented exactly one cycle after the 8th accepted beat.
